cmp_arbiter: RTL

CMP_ARBITER -- requirements
Module: cmp_arbiter

---
 rtl/cmp_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/cmp_arbiter.sv
// Two-requester round-robin front end for a shared branch comparator.
// One transaction in flight: grant in IDLE, drive comparator in ISSUE, hold response in RESP.
module cmp_arbiter #(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [3:0]      req_aluop,
    input  logic [5:0]      req_funct3,
    input  logic [13:0]     req_funct7,
    input  logic [2*DW-1:0] req_operand_a,
    input  logic [2*DW-1:0] req_operand_b,
    output logic [1:0]      cmp_aluop,
    output logic [2:0]      cmp_funct3,
    output logic [6:0]      cmp_funct7,
    output logic [DW-1:0]   cmp_operand_a,
    output logic [DW-1:0]   cmp_operand_b,
    input  logic            cmp_zero,
    input  logic [DW-1:0]   cmp_result,
    output logic [1:0]      rsp_valid,
    input  logic [1:0]      rsp_ready,
    output logic            rsp_zero,
    output logic [DW-1:0]   rsp_result
);

    // state | meaning
    // IDLE  | waiting for a request, grant offered combinationally
    // ISSUE | captured request drives the comparator for one cycle
    // RESP  | response held for the owner until rsp_ready[owner]
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t          state_q, state_d;
    logic            owner_q;
    logic            prio_q;
    logic            grant_id;
    logic            accept;
    logic            done;
    logic [1:0]      aluop_q;
    logic [2:0]      funct3_q;
    logic [6:0]      funct7_q;
    logic [DW-1:0]   opa_q;
    logic [DW-1:0]   opb_q;

    always_comb begin
        state_d       = state_q;
        req_ready     = 2'b00;
        rsp_valid     = 2'b00;
        accept        = 1'b0;
        done          = 1'b0;
        cmp_aluop     = '0;
        cmp_funct3    = '0;
        cmp_funct7    = '0;
        cmp_operand_a = '0;
        cmp_operand_b = '0;
        // prio_q names the requester that wins a tie
        if (req_valid == 2'b11)
            grant_id = prio_q;
        else
            grant_id = req_valid[1];
        case (state_q)
            IDLE: begin
                if (!rst && (req_valid != 2'b00)) begin
                    accept    = 1'b1;
                    req_ready = grant_id ? 2'b10 : 2'b01;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                cmp_aluop     = aluop_q;
                cmp_funct3    = funct3_q;
                cmp_funct7    = funct7_q;
                cmp_operand_a = opa_q;
                cmp_operand_b = opb_q;
                state_d       = RESP;
            end
            RESP: begin
                rsp_valid = owner_q ? 2'b10 : 2'b01;
                if (rsp_ready[owner_q]) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            prio_q     <= 1'b0;
            aluop_q    <= '0;
            funct3_q   <= '0;
            funct7_q   <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            rsp_zero   <= 1'b0;
            rsp_result <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q  <= grant_id;
                aluop_q  <= grant_id ? req_aluop[3:2]          : req_aluop[1:0];
                funct3_q <= grant_id ? req_funct3[5:3]         : req_funct3[2:0];
                funct7_q <= grant_id ? req_funct7[13:7]        : req_funct7[6:0];
                opa_q    <= grant_id ? req_operand_a[2*DW-1:DW] : req_operand_a[DW-1:0];
                opb_q    <= grant_id ? req_operand_b[2*DW-1:DW] : req_operand_b[DW-1:0];
            end
            if (state_q == ISSUE) begin
                rsp_zero   <= cmp_zero;
                rsp_result <= cmp_result;
            end
            if (done)
                prio_q <= ~owner_q;
        end
    end

endmodule
